ipif_axil_slave: RTL and testbench
==================================

// Module: ipif_axil_slave
// PURPOSE
// AXI4-Lite slave on the bus_clk side of an IPIF register block. Decodes AXI transactions into
// one-hot RdCE/WrCE pulses and holds the bus-written register bank (params_from_bus).
// Returns IP-side values (params_to_bus) on reads.
// Drives the bus-side inputs of IPIF_clock_converter, which forwards them to the IP clock domain.
// PARAMETERS
// C_S_AXI_DATA_WIDTH  32      data width; fixed at 32, others rejected by elaboration assert
// C_S_AXI_ADDR_WIDTH  8       byte-address width; must satisfy 2**(ADDR_W-2) >= N_REG
// N_REG               2       number of 32-bit registers
// PARAM_T             logic[N_REG*C_S_AXI_DATA_WIDTH-1:0]  packed register-bank type; packed
//                             bit width must equal N_REG*32; register i occupies bits [32i +: 32]
// RESET_VAL           '0      PARAM_T value loaded into params_from_bus on reset
// PORTS
// S_AXI_ACLK      in   1          bus clock (bus_clk)
// S_AXI_ARESETN   in   1          asynchronous active-low reset
// S_AXI_AWADDR    in   ADDR_W     write address
// S_AXI_AWVALID/AWREADY  in/out 1 write-address handshake
// S_AXI_WDATA     in   32         write data
// S_AXI_WSTRB     in   4          byte strobes
// S_AXI_WVALID/WREADY    in/out 1 write-data handshake
// S_AXI_BRESP     out  2          00 OKAY, 10 SLVERR
// S_AXI_BVALID/BREADY    out/in 1 write response
// S_AXI_ARADDR    in   ADDR_W     read address
// S_AXI_ARVALID/ARREADY  in/out 1 read-address handshake
// S_AXI_RDATA     out  32         read data
// S_AXI_RRESP     out  2          00 OKAY, 10 SLVERR
// S_AXI_RVALID/RREADY    out/in 1 read data
// RdCE            out  N_REG      one-hot read pulse, one cycle
// WrCE            out  N_REG      one-hot write pulse, one cycle
// params_from_bus out  PARAM_T    register bank written by the bus
// params_to_bus   in   PARAM_T    IP-side values returned on reads
// BEHAVIOUR
// - Reset (async assert, sync deassert edge): all READY/VALID=0, RdCE=WrCE=0, BRESP=RRESP=0,
//   RDATA=0, params_from_bus=RESET_VAL. AW/W/ARREADY go to 1 the first cycle after release.
// - Index: idx = ADDR[ADDR_W-1:2]; ADDR[1:0] ignored. idx>=N_REG is out of range.
// - Write path: AW and W each captured into a one-entry holding register; AWREADY=!aw_full,
//   WREADY=!w_full. AW and W are accepted independently, in either order or in the same cycle.
// - Write fire: cycle F where aw_full && w_full && !BVALID.
//   - In range: WrCE[idx]=1 during F only. Register bytes with WSTRB=1 are updated at the end of F,
//     so new values are visible in F+1. Bytes with WSTRB=0 are kept.
//   - Out of range: no WrCE, no update, BRESP=SLVERR.
//   - aw_full and w_full clear at the end of F. BVALID=1 from F+1 until BREADY.
// - The one-cycle gap between WrCE and the visible params_from_bus update is mandatory.
//   IPIF_clock_converter delays CE by one cycle to match it.
// - Read path: ARREADY = !ar_full && !RVALID.
//   - AR is accepted in cycle A. RdCE[idx]=1 in A+1 (none if out of range).
//   - RDATA is sampled from params_to_bus[idx] at the end of A+1. RVALID=1 from A+2 until RREADY.
//   - RRESP=SLVERR and RDATA=0 if out of range.
// - RDATA/RRESP are held stable while RVALID && !RREADY. BRESP is held while BVALID && !BREADY.
// - Read and write paths are fully independent. RdCE and WrCE may pulse in the same cycle,
//   including for the same idx. A read sees params_to_bus, not the pending write.
// - Back-pressure: if BREADY stays low, at most one further AW and one W are absorbed, then
//   AWREADY/WREADY stay 0. If RREADY stays low, ARREADY stays 0.
// - Reset mid-transaction: pending AW/W/AR are discarded, responses are dropped, no CE pulse
//   is issued, and the register bank returns to RESET_VAL.
// - Never more than one bit of RdCE high; never more than one bit of WrCE high.
// STRUCTURE
// - ipif_pkg: AXI_RESP_OKAY/AXI_RESP_SLVERR localparams, ADDR_LSB=2, and a function
//   strb_merge(old, new, strb) returning the byte-merged word.
// - Single module, no sub-modules. Write and read paths are separate always_ff blocks.
// - Register bank is accessed through a packed union of PARAM_T and
//   logic [N_REG-1:0][31:0], the same method IPIF_clock_converter uses.
// TESTING
// 1. Reset, RESET_VAL=0 -> after release AWREADY=WREADY=ARREADY=1, all outputs 0, bank 0.
// 2. AW(0x04) and W(0xDEADBEEF, strb 1111) same cycle -> WrCE=2'b10 for exactly one cycle;
//    reg1=0xDEADBEEF the next cycle; BVALID with OKAY that same next cycle.
// 3. W(0x000000AA, strb 0001) 3 cycles before AW(0x04) -> only WREADY drops, no pulse until AW;
//    reg1 becomes 0xDEADBEAA.
// 4. AR(0x00) with params_to_bus reg0=0x12345678 and RREADY low for 5 cycles -> RdCE=2'b01 one
//    cycle; RDATA=0x12345678, OKAY, held stable; ARREADY=0 until RREADY.
// 5. Write and read to 0x08 with N_REG=2 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no CE pulse,
//    bank unchanged.
// 6. S_AXI_ARESETN low for 1 cycle while BVALID is held and a read is pending -> BVALID and
//    RVALID drop, no later CE pulse, bank=RESET_VAL.

Source files
------------

// File: rtl/ipif_pkg.sv
// Shared constants and helpers for the IPIF bus-side register interface.
package ipif_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         ADDR_LSB        = 2;

  // Byte-merge a write into an existing word: strobed bytes take the new value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ipif_axil_slave.sv
// AXI4-Lite slave, bus-clock side of the IPIF register block.
// Turns AXI accesses into one-hot RdCE/WrCE pulses, owns the bus-written bank
// and returns IP-side values on reads. WrCE leads the visible bank update by
// one cycle; the clock converter delays CE to line the two up again.
module ipif_axil_slave
  import ipif_pkg::*;
#(
  parameter int  C_S_AXI_DATA_WIDTH = 32,
  parameter int  C_S_AXI_ADDR_WIDTH = 8,
  parameter int  N_REG              = 2,
  parameter type PARAM_T            = logic [N_REG*C_S_AXI_DATA_WIDTH-1:0],
  parameter PARAM_T RESET_VAL       = '0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]                      S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [N_REG-1:0]                RdCE,
  output logic [N_REG-1:0]                WrCE,
  output PARAM_T                          params_from_bus,
  input  PARAM_T                          params_to_bus
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ipif_axil_slave: C_S_AXI_DATA_WIDTH must be 32");
  end
  if ($bits(PARAM_T) != N_REG*32) begin : g_bad_param_t
    $error("ipif_axil_slave: PARAM_T width must be N_REG*32");
  end
  if ((2**IDX_W) < N_REG) begin : g_bad_addr_width
    $error("ipif_axil_slave: address width too small for N_REG");
  end

  // Same flat/word view of the bank that the clock converter uses.
  typedef union packed {
    PARAM_T                  flat;
    logic [N_REG-1:0][31:0]  word;
  } bank_t;

  logic              ready_en_q;
  logic              aw_full_q, aw_full_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  bank_t             bank_q, bank_d;
  logic              wr_fire;
  logic [N_REG-1:0]  wrce;

  logic              ar_full_q, ar_full_d;
  logic [IDX_W-1:0]  ar_idx_q, ar_idx_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [N_REG-1:0]  rdce;
  logic [31:0]       rd_word;
  bank_t             to_bus;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign to_bus.flat = params_to_bus;

  // Hold all READYs low during reset and for the release edge itself.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en_q <= 1'b0;
    else                ready_en_q <= 1'b1;
  end

  assign S_AXI_AWREADY = ready_en_q && !aw_full_q;
  assign S_AXI_WREADY  = ready_en_q && !w_full_q;
  assign S_AXI_ARREADY = ready_en_q && !ar_full_q && !rvalid_q;

  // Write path next state: capture AW/W independently, fire once both held and B is free.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bank_d    = bank_q;
    wr_fire   = aw_full_q && w_full_q && !bvalid_q;
    wrce      = '0;
    for (int i = 0; i < N_REG; i++) begin
      wrce[i] = wr_fire && (aw_idx_q == IDX_W'(i));
    end
    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    end
    if (S_AXI_WVALID && S_AXI_WREADY) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_fire) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (|wrce) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      for (int i = 0; i < N_REG; i++) begin
        if (wrce[i]) bank_d.word[i] = strb_merge(bank_q.word[i], w_data_q, w_strb_q);
      end
    end
  end

  // Write path state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= AXI_RESP_OKAY;
      bank_q.flat <= RESET_VAL;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bank_q    <= bank_d;
    end
  end

  // Read path next state: RdCE in the cycle after AR, data sampled at its end.
  always_comb begin
    ar_full_d = ar_full_q;
    ar_idx_d  = ar_idx_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rdce      = '0;
    rd_word   = '0;
    for (int i = 0; i < N_REG; i++) begin
      rdce[i] = ar_full_q && (ar_idx_q == IDX_W'(i));
      if (ar_idx_q == IDX_W'(i)) rd_word = to_bus.word[i];
    end
    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      ar_full_d = 1'b1;
      ar_idx_d  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    end
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_full_q) begin
      ar_full_d = 1'b0;
      rvalid_d  = 1'b1;
      rresp_d   = (|rdce) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      rdata_d   = (|rdce) ? rd_word : 32'h0;
    end
  end

  // Read path state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ar_full_q <= 1'b0;
      ar_idx_q  <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= AXI_RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      ar_full_q <= ar_full_d;
      ar_idx_q  <= ar_idx_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_BVALID    = bvalid_q;
  assign S_AXI_BRESP     = bresp_q;
  assign S_AXI_RVALID    = rvalid_q;
  assign S_AXI_RRESP     = rresp_q;
  assign S_AXI_RDATA     = rdata_q;
  assign WrCE            = wrce;
  assign RdCE            = rdce;
  assign params_from_bus = bank_q.flat;

endmodule

// File: tb/tb_ipif_axil_slave.sv
// Directed bench for ipif_axil_slave with a response scoreboard.
module tb_ipif_axil_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [1:0]  rdce, wrce;
  logic [63:0] from_bus, to_bus;

  logic [1:0]  exp_b[$];
  rexp_t       exp_r[$];
  logic [63:0] model_bank;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  ipif_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .RdCE(rdce), .WrCE(wrce),
    .params_from_bus(from_bus), .params_to_bus(to_bus)
  );

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string tag);
    int n = 0;
    logic [1:0] e;
    while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
    chk({tag, "_bresp"}, 64'(bresp), 64'(e));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_bdone"}, 64'(bvalid), 64'd0);
  endtask

  task automatic check_r(input string tag, input int hold);
    int n = 0;
    rexp_t e;
    while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    e = (exp_r.size() > 0) ? exp_r.pop_front() : 'x;
    for (int k = 0; k < hold; k++) begin
      chk({tag, "_rdata"}, 64'(rdata), 64'(e.data));
      chk({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
      chk({tag, "_arready_hold"}, 64'(arready), 64'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk({tag, "_rdone"}, 64'(rvalid), 64'd0);
    chk({tag, "_arready_back"}, 64'(arready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 0; rready = 0; wdata = '0; wstrb = '0; to_bus = '0; model_bank = '0;
    tick(); tick();
    chk("rst_awready_low", 64'(awready), 64'd0);
    chk("rst_arready_low", 64'(arready), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_awready", 64'(awready), 64'd1);
    chk("rel_wready", 64'(wready), 64'd1);
    chk("rel_arready", 64'(arready), 64'd1);
    chk("rel_valids", 64'({bvalid, rvalid}), 64'd0);
    chk("rel_ce", 64'({wrce, rdce}), 64'd0);
    chk("rel_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
    chk("rel_bank", from_bus, model_bank);

    // AW and W in the same cycle
    awaddr = 8'h04; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    exp_b.push_back(OKAY);
    tick();
    awvalid = 0; wvalid = 0;
    chk("t2_wrce", 64'(wrce), 64'(2'b10));
    chk("t2_bank_not_yet", from_bus, model_bank);
    chk("t2_bvalid_not_yet", 64'(bvalid), 64'd0);
    model_bank[63:32] = merge32(model_bank[63:32], 32'hDEADBEEF, 4'hF);
    tick();
    chk("t2_wrce_gone", 64'(wrce), 64'd0);
    chk("t2_bank", from_bus, model_bank);
    chk("t2_bvalid_now", 64'(bvalid), 64'd1);
    check_b("t2");

    // W three cycles ahead of AW, low byte only
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1;
    exp_b.push_back(OKAY);
    tick();
    wvalid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_wready_low", 64'(wready), 64'd0);
      chk("t3_awready_high", 64'(awready), 64'd1);
      chk("t3_no_wrce", 64'(wrce), 64'd0);
      tick();
    end
    awaddr = 8'h04; awvalid = 1;
    tick();
    awvalid = 0;
    chk("t3_wrce", 64'(wrce), 64'(2'b10));
    model_bank[63:32] = merge32(model_bank[63:32], 32'h000000AA, 4'h1);
    tick();
    chk("t3_bank", from_bus, model_bank);
    chk("t3_reg1_literal", 64'(from_bus[63:32]), 64'h00000000_DEADBEAA);
    check_b("t3");

    // Read reg0 with RREADY held low
    to_bus = {32'hCAFEF00D, 32'h12345678};
    araddr = 8'h00; arvalid = 1;
    exp_r.push_back('{data: 32'h12345678, resp: OKAY});
    tick();
    arvalid = 0;
    chk("t4_rdce", 64'(rdce), 64'(2'b01));
    chk("t4_arready_busy", 64'(arready), 64'd0);
    chk("t4_rvalid_not_yet", 64'(rvalid), 64'd0);
    tick();
    chk("t4_rdce_gone", 64'(rdce), 64'd0);
    to_bus = {32'hCAFEF00D, 32'hFFFF0000};
    check_r("t4", 5);

    // Out-of-range write and read together
    awaddr = 8'h08; awvalid = 1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1;
    araddr = 8'h08; arvalid = 1;
    exp_b.push_back(SLVERR);
    exp_r.push_back('{data: 32'h0, resp: SLVERR});
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t5_no_ce_a", 64'({wrce, rdce}), 64'd0);
    tick();
    chk("t5_no_ce_b", 64'({wrce, rdce}), 64'd0);
    chk("t5_bank", from_bus, model_bank);
    check_b("t5");
    check_r("t5", 1);

    // Reset with a held B response, absorbed AW/W and a pending read
    to_bus = {32'h0BADF00D, 32'h76543210};
    awaddr = 8'h00; awvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t6_wrce", 64'(wrce), 64'(2'b01));
    model_bank[31:0] = 32'h55AA55AA;
    tick();
    chk("t6_bvalid", 64'(bvalid), 64'd1);
    chk("t6_bank", from_bus, model_bank);
    awaddr = 8'h04; awvalid = 1; wdata = 32'h99999999; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t6_bp_awready", 64'(awready), 64'd0);
    chk("t6_bp_wready", 64'(wready), 64'd0);
    chk("t6_bp_no_wrce", 64'(wrce), 64'd0);
    araddr = 8'h04; arvalid = 1;
    tick();
    arvalid = 0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valids", 64'({bvalid, rvalid}), 64'd0);
    chk("t6_rst_ce", 64'({wrce, rdce}), 64'd0);
    exp_b.delete();
    exp_r.delete();
    model_bank = '0;
    chk("t6_rst_bank", from_bus, model_bank);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_post_ce", 64'({wrce, rdce}), 64'd0);
      chk("t6_post_valids", 64'({bvalid, rvalid}), 64'd0);
      chk("t6_post_bank", from_bus, model_bank);
    end
    chk("t6_post_awready", 64'(awready), 64'd1);

    // Bank usable again after reset
    awaddr = 8'h00; awvalid = 1; wdata = 32'h1234FFFF; wstrb = 4'h3; wvalid = 1;
    exp_b.push_back(OKAY);
    tick();
    awvalid = 0; wvalid = 0;
    model_bank[31:0] = merge32(model_bank[31:0], 32'h1234FFFF, 4'h3);
    tick();
    chk("t7_bank", from_bus, model_bank);
    check_b("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
